// File: rtl/nco_acq_ctrl_if.sv
// nco_acq_ctrl_if
//   Bundles the control/status signals of the NCO acquisition controller.
//   master : the environment driving start/abort/metrics/loop error and
//            observing the NCO word and status.
//   slave  : the controller itself.
//   Signals:
//     start        pulse, begin acquisition (IDLE/FAIL only)
//     abort        pulse, return to IDLE from any state
//     metric_valid qualifies lock_metric
//     lock_metric  signed 16-bit lock detector output
//     loop_err     signed 32-bit loop-filter output (used in TRACK)
//     phase        signed 32-bit NCO phase/frequency word (registered)
//     state        3-bit state code (0 IDLE,1 SWEEP,2 DWELL,3 TRACK,4 FAIL)
//     locked       high in TRACK
//     acq_fail     high in FAIL
//     sat          NCO word clamped this cycle
interface nco_acq_ctrl_if;
  logic        start;
  logic        abort;
  logic        metric_valid;
  logic [15:0] lock_metric;
  logic [31:0] loop_err;
  logic [31:0] phase;
  logic [2:0]  state;
  logic        locked;
  logic        acq_fail;
  logic        sat;

  modport master (
    output start, abort, metric_valid, lock_metric, loop_err,
    input  phase, state, locked, acq_fail, sat
  );

  modport slave (
    input  start, abort, metric_valid, lock_metric, loop_err,
    output phase, state, locked, acq_fail, sat
  );
endinterface

// File: rtl/nco_acq_ctrl.sv
// nco_acq_ctrl
//   Acquisition/tracking controller for a Costas-loop NCO. Sweeps a
//   frequency offset in dwell steps until the lock metric holds above
//   threshold, then tracks by adding the loop-filter error to the locked
//   offset. Re-sweeps on lock loss and flags failure after MAX_PASSES
//   complete sweeps without lock.
//   Ports:
//     clk_i  clock
//     rst_i  synchronous reset, active-low
//     bus    nco_acq_ctrl_if.slave (handshake, metrics, NCO word, status)
//   Build option:
//     NCO_SAT_EN  defined   -> offset+loop_err clamped to signed 32-bit range,
//                              sat flags clamped cycles
//                 undefined -> offset+loop_err wraps to 32 bits, sat stays 0
//
//   state  | meaning
//   IDLE   | NCO word 0, waiting for start
//   SWEEP  | one cycle: apply current offset, clear dwell/hit counters
//   DWELL  | count dwell cycles and consecutive hits at this offset
//   TRACK  | phase = offset + loop_err, watch for consecutive misses
//   FAIL   | no lock after MAX_PASSES sweeps, NCO word 0, wait for start
module nco_acq_ctrl #(
  parameter logic signed [31:0] SWEEP_MIN  = -32'sd4000000,
  parameter logic signed [31:0] SWEEP_MAX  =  32'sd4000000,
  parameter logic signed [31:0] SWEEP_STEP =  32'sd250000,
  parameter int                 DWELL_CYC  = 64,
  parameter logic signed [15:0] LOCK_THR   = 16'sd8000,
  parameter int                 LOCK_CNT   = 4,
  parameter int                 UNLOCK_CNT = 32,
  parameter int                 MAX_PASSES = 3
) (
  input logic           clk_i,
  input logic           rst_i,
  nco_acq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SWEEP = 3'd1,
    S_DWELL = 3'd2,
    S_TRACK = 3'd3,
    S_FAIL  = 3'd4
  } state_e;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYC - 1);
  localparam logic [15:0] LOCK_N     = 16'(LOCK_CNT);
  localparam logic [15:0] UNLOCK_N   = 16'(UNLOCK_CNT);
  localparam logic [7:0]  PASS_N     = 8'(MAX_PASSES);

  state_e      state_q;
  logic [31:0] offset_q;
  logic [31:0] phase_q;
  logic        locked_q;
  logic        acq_fail_q;
  logic        sat_q;
  logic [15:0] dwell_cnt_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic [7:0]  pass_q;

  logic               hit;
  logic [15:0]        hit_cnt_d;
  logic [15:0]        miss_cnt_d;
  logic [7:0]         pass_d;
  logic signed [32:0] step_sum;
  logic signed [32:0] sweep_max_x;
  logic               step_wrap;
  logic signed [32:0] trk_sum;
  logic [31:0]        trk_phase_d;
  logic               trk_sat_d;

  always_comb begin
    hit = $signed(bus.lock_metric) >= LOCK_THR;

    // A valid miss breaks the hit run; an invalid sample leaves it alone.
    hit_cnt_d = hit_cnt_q;
    if (bus.metric_valid) hit_cnt_d = hit ? hit_cnt_q + 16'd1 : 16'd0;

    miss_cnt_d = miss_cnt_q;
    if (bus.metric_valid) miss_cnt_d = hit ? 16'd0 : miss_cnt_q + 16'd1;

    pass_d = pass_q + 8'd1;

    // 33-bit compare so a step past SWEEP_MAX near the 32-bit limit still wraps.
    step_sum    = $signed({offset_q[31], offset_q}) + $signed({SWEEP_STEP[31], SWEEP_STEP});
    sweep_max_x = $signed({SWEEP_MAX[31], SWEEP_MAX});
    step_wrap   = step_sum > sweep_max_x;

    trk_sum = $signed({offset_q[31], offset_q}) + $signed({bus.loop_err[31], bus.loop_err});
`ifdef NCO_SAT_EN
    // Bits 32 and 31 disagree only when the sum left the 32-bit range.
    trk_sat_d   = trk_sum[32] != trk_sum[31];
    trk_phase_d = trk_sum[31:0];
    if (trk_sat_d) trk_phase_d = trk_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    trk_sat_d   = 1'b0;
    trk_phase_d = trk_sum[31:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || bus.abort) begin
      state_q     <= S_IDLE;
      offset_q    <= '0;
      phase_q     <= '0;
      locked_q    <= 1'b0;
      acq_fail_q  <= 1'b0;
      sat_q       <= 1'b0;
      dwell_cnt_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      pass_q      <= '0;
    end else begin
      sat_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q  <= S_SWEEP;
            offset_q <= SWEEP_MIN;
            pass_q   <= '0;
          end
        end
        S_SWEEP: begin
          phase_q     <= offset_q;
          dwell_cnt_q <= '0;
          hit_cnt_q   <= '0;
          state_q     <= S_DWELL;
        end
        S_DWELL: begin
          dwell_cnt_q <= dwell_cnt_q + 16'd1;
          hit_cnt_q   <= hit_cnt_d;
          // Lock takes priority over the end of the dwell window.
          if (hit_cnt_d == LOCK_N) begin
            state_q    <= S_TRACK;
            locked_q   <= 1'b1;
            miss_cnt_q <= '0;
          end else if (dwell_cnt_q == DWELL_LAST) begin
            if (step_wrap) begin
              offset_q <= SWEEP_MIN;
              pass_q   <= pass_d;
              if (pass_d == PASS_N) begin
                state_q    <= S_FAIL;
                acq_fail_q <= 1'b1;
                phase_q    <= '0;
              end else begin
                state_q <= S_SWEEP;
              end
            end else begin
              offset_q <= step_sum[31:0];
              state_q  <= S_SWEEP;
            end
          end
        end
        S_TRACK: begin
          phase_q    <= trk_phase_d;
          sat_q      <= trk_sat_d;
          miss_cnt_q <= miss_cnt_d;
          // Lock loss re-sweeps from the current offset with a fresh pass budget.
          if (miss_cnt_d == UNLOCK_N) begin
            state_q  <= S_SWEEP;
            pass_q   <= '0;
            locked_q <= 1'b0;
          end
        end
        S_FAIL: begin
          if (bus.start) begin
            state_q    <= S_SWEEP;
            offset_q   <= SWEEP_MIN;
            pass_q     <= '0;
            acq_fail_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.phase    = phase_q;
  assign bus.state    = state_q;
  assign bus.locked   = locked_q;
  assign bus.acq_fail = acq_fail_q;
  assign bus.sat      = sat_q;

endmodule
